t05_hd_decode_gen: RTL and testbench
====================================

Name: t05_hd_decode_gen

Overview:
- Parametrised next-generation Huffman header decoder for the team_05 decompression path.
- Consumes a pre-order serialised code tree, then a total-character count, from a byte-wide SPI stream.
- Writes one codeword record (symbol-addressed path plus explicit length) per leaf into the codebook SRAM.
- Adds over the previous decoder: valid/ready input, acknowledged SRAM writes, a depth-overflow error, and parametrised symbol, depth and count widths.

Parameters:
- CHAR_W, 8, symbol width in bits; also the SRAM address width.
- MAX_DEPTH, 128, maximum code length; width of the path register and of sram_data.
- TOT_W, 32, width of the total-character field.
- LEN_W, 8, width of sram_len; must satisfy 2^LEN_W > MAX_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- hd_enable  in  1  level enable; low aborts to IDLE.
- start  in  1  one-cycle pulse; begins decode from IDLE.
- spi_data  in  8  header byte, MSB consumed first.
- spi_valid  in  1  spi_data valid.
- spi_ready  out  1  byte accepted when spi_valid && spi_ready.
- sram_wr_en  out  1  write request; held until acknowledged.
- sram_ack  in  1  write accepted this cycle.
- sram_addr  out  CHAR_W  symbol = codebook address.
- sram_data  out  MAX_DEPTH  code bits, right-aligned; bit len-1 is the first move; 0=left, 1=right.
- sram_len  out  LEN_W  code length.
- tot_chars  out  TOT_W  decoded total-character count.
- finished  out  1  sticky done.
- error  out  1  sticky depth overflow.
- busy  out  1  not in IDLE/DONE/ERR.

Behaviour:
- Reset: all outputs 0; state IDLE; path 0; depth 0; bit buffer empty.
- Bitstream format:
  - Node bit 0 = internal node. Node bit 1 = leaf, followed by CHAR_W symbol bits, MSB first.
  - After the final leaf: TOT_W count bits, MSB first.
  - Trailing pad bits in the last byte are ignored.
- Bit buffer:
  - 8-bit shift register plus 4-bit count.
  - spi_ready=1 only when count==0 and the state needs a bit.
  - An accepted byte loads count=8; its bits are usable from the next cycle.
  - At most one bit is consumed per cycle.
- States: IDLE, NODE, SYM, EMIT, POP, TOT, DONE, ERR.
- IDLE: start && hd_enable -> NODE; clear path, depth, tot_chars, finished, error.
- NODE: consume one bit.
  - 0 with depth==MAX_DEPTH -> ERR.
  - 0 otherwise: path={path,0}, depth+1, stay in NODE.
  - 1 -> SYM with a symbol-bit counter of 0.
- SYM: shift CHAR_W bits into the symbol register; after the last bit -> EMIT.
- EMIT:
  - sram_wr_en=1; addr, data and len are stable while waiting.
  - If depth==0 (root is a leaf), emit data=0, len=1.
  - Otherwise emit data=path, len=depth.
  - On sram_ack -> POP. No bits are consumed while in EMIT.
- POP: one action per cycle.
  - path[0]==1 and depth>0: shift right, depth-1.
  - depth==0: tree complete -> TOT.
  - Otherwise (path[0]==0): path[0]=1 -> NODE.
- TOT: shift TOT_W bits into tot_chars; after the last bit -> DONE.
- DONE: finished=1, held until start or reset. start from DONE re-enters NODE with cleared state.
- ERR: error=1, sram_wr_en=0, held until start (as from DONE) or reset.
- hd_enable low in any state: synchronously return to IDLE next cycle.
  - sram_wr_en and spi_ready are forced 0 in that same cycle.
  - finished, error and tot_chars keep their values.
  - The bit buffer is flushed.
- Simultaneous events:
  - spi_valid arriving while count>0 is not accepted.
  - sram_ack outside EMIT is ignored.
  - start while busy is ignored.

Optional Feature:
- Macro T05_HD_LEAF_CNT_EN.
- When defined:
  - Extra output leaf_count [CHAR_W:0] counts acknowledged EMIT writes; cleared on start and reset.
  - Transition to DONE additionally requires leaf_count >= 1.
  - A second leaf that uses an already-written symbol sets error and goes to ERR instead of EMIT. Duplicates are detected with a 2^CHAR_W-bit seen bitmap.
- When undefined: no leaf_count port, no bitmap, no duplicate check.

Test Plan:
- Defaults, two-leaf stream:
  - Stimulus bits 0,1,0x41,1,0x42, then 0x00000005, padded to 7 bytes.
  - Required: writes (0x41,data 0,len1), then (0x42,data 1,len1); tot_chars=5; finished=1; error=0.
- Three leaves:
  - Stimulus bits 0,0,1,'a',1,'b',1,'c', then count 3.
  - Required: a=00/len2, b=01/len2, c=1/len1, in that order; tot_chars=3.
- Root leaf:
  - Stimulus bits 1,0x5A, then count 7.
  - Required: single write addr 0x5A, data 0, len 1; finished.
- MAX_DEPTH=4:
  - Stimulus: five 0 node bits.
  - Required: error=1, state ERR, no SRAM writes, spi_ready=0.
- Backpressure:
  - Stimulus: sram_ack delayed 3 cycles; spi_valid toggled every other cycle.
  - Required: sram_wr_en held with stable addr/data/len; identical write sequence and tot_chars to the unstalled run.
- Abort:
  - Stimulus: hd_enable low mid-SYM; separately, rst low mid-EMIT.
  - Required: IDLE within one cycle; sram_wr_en=0. The rst case additionally clears all outputs. A fresh start then decodes correctly.

Source files
------------

// File: rtl/t05_hd_decode_gen_if.sv
// Header-decoder bus: byte-wide SPI input handshake plus acknowledged codebook SRAM write port.
// master = the decoder side, slave = the stream source / SRAM side.
interface t05_hd_decode_gen_if #(
   parameter int CHAR_W    = 8,
   parameter int MAX_DEPTH = 128,
   parameter int LEN_W     = 8
);
   logic [7:0]           spi_data;
   logic                 spi_valid;
   logic                 spi_ready;
   logic                 sram_wr_en;
   logic                 sram_ack;
   logic [CHAR_W-1:0]    sram_addr;
   logic [MAX_DEPTH-1:0] sram_data;
   logic [LEN_W-1:0]     sram_len;

   modport master (
      input  spi_data, spi_valid, sram_ack,
      output spi_ready, sram_wr_en, sram_addr, sram_data, sram_len
   );

   modport slave (
      output spi_data, spi_valid, sram_ack,
      input  spi_ready, sram_wr_en, sram_addr, sram_data, sram_len
   );
endinterface

// File: rtl/t05_hd_decode_gen.sv
// Huffman header decoder: pre-order code tree + total count from SPI bytes, one codebook write per leaf.
// Optional T05_HD_LEAF_CNT_EN adds a leaf_count output and duplicate-symbol detection.
module t05_hd_decode_gen #(
   parameter int CHAR_W    = 8,
   parameter int MAX_DEPTH = 128,
   parameter int TOT_W     = 32,
   parameter int LEN_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hd_enable,
   input  logic                 start,
   t05_hd_decode_gen_if.master  bus,
   output logic [TOT_W-1:0]     tot_chars,
   output logic                 finished,
   output logic                 error,
   output logic                 busy
`ifdef T05_HD_LEAF_CNT_EN
   ,
   output logic [CHAR_W:0]      leaf_count
`endif
);

   localparam int CNT_MAX = (TOT_W > CHAR_W) ? TOT_W : CHAR_W;
   localparam int BC_W    = $clog2(CNT_MAX) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_NODE, S_SYM, S_EMIT, S_POP, S_TOT, S_DONE, S_ERR
   } state_t;

   state_t               state_q, state_d;
   logic [7:0]           buf_q, buf_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [MAX_DEPTH-1:0] path_q, path_d;
   logic [LEN_W-1:0]     depth_q, depth_d;
   logic [CHAR_W-1:0]    sym_q, sym_d;
   logic [BC_W-1:0]      bc_q, bc_d;
   logic [TOT_W-1:0]     tot_q, tot_d;
   logic                 fin_q, fin_d;
   logic                 err_q, err_d;
`ifdef T05_HD_LEAF_CNT_EN
   logic [CHAR_W:0]          lc_q, lc_d;
   logic [2**CHAR_W-1:0]     seen_q, seen_d;
`endif

   logic                 need_bit;
   logic                 take_bit;
   logic                 cur_bit;
   logic                 spi_rdy;
   logic [CHAR_W-1:0]    sym_shift;
   logic                 wr_en;
   logic [CHAR_W-1:0]    wr_addr;
   logic [MAX_DEPTH-1:0] wr_data;
   logic [LEN_W-1:0]     wr_len;

   assign need_bit  = (state_q == S_NODE) || (state_q == S_SYM) || (state_q == S_TOT);
   assign cur_bit   = buf_q[7];
   assign take_bit  = hd_enable && need_bit && (cnt_q != 4'd0);
   assign spi_rdy   = hd_enable && need_bit && (cnt_q == 4'd0);
   assign sym_shift = {sym_q[CHAR_W-2:0], cur_bit};

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      path_d  = path_q;
      depth_d = depth_q;
      sym_d   = sym_q;
      bc_d    = bc_q;
      tot_d   = tot_q;
      fin_d   = fin_q;
      err_d   = err_q;
`ifdef T05_HD_LEAF_CNT_EN
      lc_d    = lc_q;
      seen_d  = seen_q;
`endif
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      wr_len  = '0;

      // Loading and consuming are exclusive: a byte is only accepted with the buffer empty.
      if (bus.spi_valid && spi_rdy) begin
         buf_d = bus.spi_data;
         cnt_d = 4'd8;
      end else if (take_bit) begin
         buf_d = {buf_q[6:0], 1'b0};
         cnt_d = cnt_q - 4'd1;
      end

      if (!hd_enable) begin
         state_d = S_IDLE;
         buf_d   = '0;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state_d = S_NODE;
                  buf_d   = '0;
                  cnt_d   = 4'd0;
                  path_d  = '0;
                  depth_d = '0;
                  sym_d   = '0;
                  bc_d    = '0;
                  tot_d   = '0;
                  fin_d   = 1'b0;
                  err_d   = 1'b0;
`ifdef T05_HD_LEAF_CNT_EN
                  lc_d    = '0;
                  seen_d  = '0;
`endif
               end
            end

            S_NODE: begin
               if (take_bit) begin
                  if (cur_bit) begin
                     state_d = S_SYM;
                     bc_d    = '0;
                  end else if (depth_q == LEN_W'(MAX_DEPTH)) begin
                     state_d = S_ERR;
                     err_d   = 1'b1;
                  end else begin
                     path_d  = {path_q[MAX_DEPTH-2:0], 1'b0};
                     depth_d = depth_q + LEN_W'(1);
                  end
               end
            end

            S_SYM: begin
               if (take_bit) begin
                  sym_d = sym_shift;
                  if (bc_q == BC_W'(CHAR_W - 1)) begin
`ifdef T05_HD_LEAF_CNT_EN
                     if (seen_q[sym_shift]) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                     end else begin
                        state_d = S_EMIT;
                     end
`else
                     state_d = S_EMIT;
`endif
                  end else begin
                     bc_d = bc_q + BC_W'(1);
                  end
               end
            end

            S_EMIT: begin
               wr_en   = 1'b1;
               wr_addr = sym_q;
               // A leaf at the root still needs a one-bit code.
               if (depth_q == '0) begin
                  wr_data = '0;
                  wr_len  = LEN_W'(1);
               end else begin
                  wr_data = path_q;
                  wr_len  = depth_q;
               end
               if (bus.sram_ack) begin
                  state_d = S_POP;
`ifdef T05_HD_LEAF_CNT_EN
                  lc_d            = lc_q + 1'b1;
                  seen_d[sym_q]   = 1'b1;
`endif
               end
            end

            S_POP: begin
               // Unwind right branches one level per cycle, then take the next right sibling.
               if (path_q[0] && (depth_q != '0)) begin
                  path_d  = path_q >> 1;
                  depth_d = depth_q - LEN_W'(1);
               end else if (depth_q == '0) begin
                  state_d = S_TOT;
                  bc_d    = '0;
               end else begin
                  path_d[0] = 1'b1;
                  state_d   = S_NODE;
               end
            end

            S_TOT: begin
               if (take_bit) begin
                  tot_d = {tot_q[TOT_W-2:0], cur_bit};
                  if (bc_q == BC_W'(TOT_W - 1)) begin
`ifdef T05_HD_LEAF_CNT_EN
                     if (lc_q != '0) begin
                        state_d = S_DONE;
                        fin_d   = 1'b1;
                     end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                     end
`else
                     state_d = S_DONE;
                     fin_d   = 1'b1;
`endif
                  end else begin
                     bc_d = bc_q + BC_W'(1);
                  end
               end
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         buf_q   <= '0;
         cnt_q   <= '0;
         path_q  <= '0;
         depth_q <= '0;
         sym_q   <= '0;
         bc_q    <= '0;
         tot_q   <= '0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef T05_HD_LEAF_CNT_EN
         lc_q    <= '0;
         seen_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         path_q  <= path_d;
         depth_q <= depth_d;
         sym_q   <= sym_d;
         bc_q    <= bc_d;
         tot_q   <= tot_d;
         fin_q   <= fin_d;
         err_q   <= err_d;
`ifdef T05_HD_LEAF_CNT_EN
         lc_q    <= lc_d;
         seen_q  <= seen_d;
`endif
      end
   end

   assign bus.spi_ready  = spi_rdy;
   assign bus.sram_wr_en = wr_en;
   assign bus.sram_addr  = wr_addr;
   assign bus.sram_data  = wr_data;
   assign bus.sram_len   = wr_len;

   assign tot_chars = tot_q;
   assign finished  = fin_q;
   assign error     = err_q;
   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
`ifdef T05_HD_LEAF_CNT_EN
   assign leaf_count = lc_q;
`endif

endmodule

// File: tb/tb_t05_hd_decode_gen.sv
// Directed bench for t05_hd_decode_gen: default-parameter decoder plus a MAX_DEPTH=4 instance.
module tb_t05_hd_decode_gen;
   localparam int CHAR_W    = 8;
   localparam int MAX_DEPTH = 128;
   localparam int TOT_W     = 32;
   localparam int LEN_W     = 8;
   localparam int BUDGET    = 2000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, hd_enable, start;
   logic [TOT_W-1:0] tot_chars;
   logic             finished, error, busy;

   logic             hd_enable4, start4;
   logic [TOT_W-1:0] tot4;
   logic             fin4, err4, busy4;

   t05_hd_decode_gen_if #(.CHAR_W(CHAR_W), .MAX_DEPTH(MAX_DEPTH), .LEN_W(LEN_W)) bus ();
   t05_hd_decode_gen_if #(.CHAR_W(CHAR_W), .MAX_DEPTH(4), .LEN_W(3)) bus4 ();

   t05_hd_decode_gen #(.CHAR_W(CHAR_W), .MAX_DEPTH(MAX_DEPTH), .TOT_W(TOT_W), .LEN_W(LEN_W)) u_dut (
      .clk(clk), .rst(rst), .hd_enable(hd_enable), .start(start), .bus(bus),
      .tot_chars(tot_chars), .finished(finished), .error(error), .busy(busy)
   );

   t05_hd_decode_gen #(.CHAR_W(CHAR_W), .MAX_DEPTH(4), .TOT_W(TOT_W), .LEN_W(3)) u_dut4 (
      .clk(clk), .rst(rst), .hd_enable(hd_enable4), .start(start4), .bus(bus4),
      .tot_chars(tot4), .finished(fin4), .error(err4), .busy(busy4)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic                 bits_q[$];
   logic [7:0]           bytes_q[$];
   logic [CHAR_W-1:0]    wa_q[$], ea_q[$];
   logic [MAX_DEPTH-1:0] wd_q[$], ed_q[$];
   logic [LEN_W-1:0]     wl_q[$], el_q[$];
   int                   bytes_used;

   task automatic add_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
   endtask

   task automatic pack();
      logic [7:0] b;
      bytes_q.delete();
      while (bits_q.size() > 0) begin
         b = '0;
         for (int i = 7; i >= 0; i--)
            if (bits_q.size() > 0) b[i] = bits_q.pop_front();
         bytes_q.push_back(b);
      end
   endtask

   task automatic add_exp(input logic [CHAR_W-1:0] a, input logic [MAX_DEPTH-1:0] d,
                          input logic [LEN_W-1:0] l);
      ea_q.push_back(a);
      ed_q.push_back(d);
      el_q.push_back(l);
   endtask

   task automatic stream_two();
      bits_q.delete(); ea_q.delete(); ed_q.delete(); el_q.delete();
      add_bits(0, 1); add_bits(1, 1); add_bits(32'h41, 8);
      add_bits(1, 1); add_bits(32'h42, 8); add_bits(5, 32);
      pack();
      add_exp(8'h41, 0, 1);
      add_exp(8'h42, 1, 1);
   endtask

   task automatic stream_three();
      bits_q.delete(); ea_q.delete(); ed_q.delete(); el_q.delete();
      add_bits(0, 1); add_bits(0, 1);
      add_bits(1, 1); add_bits(32'h61, 8);
      add_bits(1, 1); add_bits(32'h62, 8);
      add_bits(1, 1); add_bits(32'h63, 8);
      add_bits(3, 32);
      pack();
      add_exp(8'h61, 0, 2);
      add_exp(8'h62, 1, 2);
      add_exp(8'h63, 1, 1);
   endtask

   task automatic stream_root();
      bits_q.delete(); ea_q.delete(); ed_q.delete(); el_q.delete();
      add_bits(1, 1); add_bits(32'h5A, 8); add_bits(7, 32);
      pack();
      add_exp(8'h5A, 0, 1);
   endtask

   // Pulses start, feeds bytes_q, acks writes after ack_delay stall cycles, logs writes.
   task automatic run(input int ack_delay, input bit toggle, input bit stop_at_wr, input int stop_after);
      int idx, cyc, wt;
      bit done;
      logic [CHAR_W-1:0]    ra;
      logic [MAX_DEPTH-1:0] rd;
      logic [LEN_W-1:0]     rl;
      idx = 0; cyc = 0; wt = 0; done = 1'b0;
      ra = '0; rd = '0; rl = '0;
      wa_q.delete(); wd_q.delete(); wl_q.delete();
      while (!done) begin
         @(negedge clk);
         if (cyc > 0 && (finished || error)) done = 1'b1;
         else if (stop_at_wr && bus.sram_wr_en) done = 1'b1;
         else if (stop_after > 0 && cyc == stop_after) done = 1'b1;
         else if (cyc >= BUDGET) begin
            check("run_timeout", finished | error, 1);
            done = 1'b1;
         end
         if (done) begin
            start = 1'b0;
            bus.spi_valid = 1'b0;
            bus.sram_ack = 1'b0;
         end else begin
            start = (cyc == 0);
            if (idx < bytes_q.size() && (!toggle || (cyc % 2) == 0)) begin
               bus.spi_valid = 1'b1;
               bus.spi_data  = bytes_q[idx];
            end else begin
               bus.spi_valid = 1'b0;
               bus.spi_data  = '0;
            end
            if (bus.spi_valid && bus.spi_ready) idx++;
            if (bus.sram_wr_en) begin
               if (wt == 0) begin
                  ra = bus.sram_addr; rd = bus.sram_data; rl = bus.sram_len;
               end else begin
                  check("hold_addr", bus.sram_addr, ra);
                  check("hold_data", bus.sram_data, rd);
                  check("hold_len", bus.sram_len, rl);
               end
               if (wt >= ack_delay) begin
                  bus.sram_ack = 1'b1;
                  wa_q.push_back(bus.sram_addr);
                  wd_q.push_back(bus.sram_data);
                  wl_q.push_back(bus.sram_len);
                  wt = 0;
               end else begin
                  bus.sram_ack = 1'b0;
                  wt++;
               end
            end else begin
               bus.sram_ack = 1'b0;
               wt = 0;
            end
            cyc++;
         end
      end
      bytes_used = idx;
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_nwr"}, wa_q.size(), ea_q.size());
      for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), wa_q[i], ea_q[i]);
         check($sformatf("%s_data%0d", tag, i), wd_q[i], ed_q[i]);
         check($sformatf("%s_len%0d", tag, i), wl_q[i], el_q[i]);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_wr_en"}, bus.sram_wr_en, 0);
      check({tag, "_spi_ready"}, bus.spi_ready, 0);
      check({tag, "_addr"}, bus.sram_addr, 0);
      check({tag, "_data"}, bus.sram_data, 0);
      check({tag, "_len"}, bus.sram_len, 0);
      check({tag, "_tot"}, tot_chars, 0);
      check({tag, "_fin"}, finished, 0);
      check({tag, "_err"}, error, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int wr4;
      rst = 1'b0; hd_enable = 1'b0; start = 1'b0;
      hd_enable4 = 1'b0; start4 = 1'b0;
      bus.spi_valid = 1'b0; bus.spi_data = '0; bus.sram_ack = 1'b0;
      bus4.spi_valid = 1'b0; bus4.spi_data = '0; bus4.sram_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b1; hd_enable = 1'b1; hd_enable4 = 1'b1;
      @(negedge clk);

      stream_two();
      run(0, 1'b0, 1'b0, 0);
      check_writes("two");
      check("two_tot", tot_chars, 5);
      check("two_fin", finished, 1);
      check("two_err", error, 0);
      check("two_busy", busy, 0);
      check("two_bytes", bytes_used, bytes_q.size());

      stream_three();
      run(0, 1'b0, 1'b0, 0);
      check_writes("three");
      check("three_tot", tot_chars, 3);
      check("three_fin", finished, 1);

      stream_root();
      run(0, 1'b0, 1'b0, 0);
      check_writes("root");
      check("root_tot", tot_chars, 7);
      check("root_fin", finished, 1);

      // Depth overflow on the MAX_DEPTH=4 instance: all-zero byte gives five internal nodes.
      wr4 = 0;
      @(negedge clk); start4 = 1'b1;
      @(negedge clk); start4 = 1'b0; bus4.spi_valid = 1'b1; bus4.spi_data = 8'h00;
      for (int c = 0; c < 40 && !err4; c++) begin
         @(negedge clk);
         if (bus4.sram_wr_en) wr4++;
      end
      bus4.spi_valid = 1'b0;
      @(negedge clk);
      check("ovf_err", err4, 1);
      check("ovf_nwr", wr4, 0);
      check("ovf_spi_ready", bus4.spi_ready, 0);
      check("ovf_busy", busy4, 0);
      check("ovf_fin", fin4, 0);

      stream_two();
      run(3, 1'b1, 1'b0, 0);
      check_writes("bp");
      check("bp_tot", tot_chars, 5);
      check("bp_fin", finished, 1);

      // Abort mid-symbol by dropping hd_enable.
      stream_three();
      run(0, 1'b0, 1'b0, 8);
      check("abort_busy_before", busy, 1);
      hd_enable = 1'b0;
      #1;
      check("abort_wr_en", bus.sram_wr_en, 0);
      check("abort_spi_ready", bus.spi_ready, 0);
      @(negedge clk);
      check("abort_busy_after", busy, 0);
      check("abort_fin", finished, 0);
      hd_enable = 1'b1;
      run(0, 1'b0, 1'b0, 0);
      check_writes("after_abort");
      check("after_abort_tot", tot_chars, 3);

      // Reset while a write is pending.
      stream_root();
      run(100, 1'b0, 1'b1, 0);
      check("rst_emit_wr_en", bus.sram_wr_en, 1);
      check("rst_emit_addr", bus.sram_addr, 8'h5A);
      rst = 1'b0;
      #1;
      check_idle_outputs("rst_emit");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run(0, 1'b0, 1'b0, 0);
      check_writes("after_rst");
      check("after_rst_tot", tot_chars, 7);
      check("after_rst_fin", finished, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
